// File: rtl/variable_delay_buffer.sv
// -----------------------------------------------------------------------------
// variable_delay_buffer
//   Multi-channel delay line whose depth is chosen at run time. A sample
//   accepted on an enabled cycle reappears on out0 after D+1 enabled cycles,
//   where D is latched (and clamped to MAX_DELAY) on a run pulse.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active-high
//   run        one-cycle pulse: latch delay, restart fill, discard in0
//   enable     advance the line by one sample
//   delay      requested delay D, sampled only while run=1
//   in0        NUM_CH packed samples, channel c at [c*DATA_W +: DATA_W]
//   out0       delayed samples, registered, same packing as in0
//   out_valid  registered; out0 carries data accepted since the last run
//   delay_cur  currently latched (clamped) delay
//
// Build option
//   VDB_ZERO_FILL_EN  when defined, out0 is forced to zero on enabled cycles
//                     before the line has filled, hiding stale storage.
// -----------------------------------------------------------------------------
module variable_delay_buffer #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned NUM_CH    = 1,
   parameter int unsigned MAX_DELAY = 8,
   localparam int unsigned DELAY_W  = $clog2(MAX_DELAY + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     run,
   input  logic                     enable,
   input  logic [DELAY_W-1:0]       delay,
   input  logic [NUM_CH*DATA_W-1:0] in0,
   output logic [NUM_CH*DATA_W-1:0] out0,
   output logic                     out_valid,
   output logic [DELAY_W-1:0]       delay_cur
);

   localparam int unsigned BUS_W  = NUM_CH * DATA_W;
   localparam int unsigned PTR_W  = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
   // Wide enough to hold wptr + MAX_DELAY without overflow.
   localparam int unsigned CALC_W = DELAY_W + 1;

   // All channels share pointers, so one storage word holds every channel.
   logic [BUS_W-1:0]   mem_q [MAX_DELAY];

   logic [PTR_W-1:0]   wptr_q,  wptr_d;
   logic [DELAY_W-1:0] cnt_q,   cnt_d;
   logic [DELAY_W-1:0] delay_q, delay_d;
   logic [BUS_W-1:0]   out_q,   out_d;
   logic               valid_q, valid_d;

   logic               mem_we_c;
   logic [PTR_W-1:0]   rptr_c;
   logic [CALC_W-1:0]  wptr_ext_c;
   logic [CALC_W-1:0]  dly_ext_c;
   logic [CALC_W-1:0]  rptr_ext_c;

   // Read index D entries behind the write pointer, modulo MAX_DELAY.
   always_comb begin
      wptr_ext_c = CALC_W'(wptr_q);
      dly_ext_c  = CALC_W'(delay_q);
      if (wptr_ext_c >= dly_ext_c) begin
         rptr_ext_c = wptr_ext_c - dly_ext_c;
      end else begin
         rptr_ext_c = wptr_ext_c + CALC_W'(MAX_DELAY) - dly_ext_c;
      end
      rptr_c = PTR_W'(rptr_ext_c);
   end

   // Next-state logic; run takes priority over enable.
   always_comb begin
      wptr_d   = wptr_q;
      cnt_d    = cnt_q;
      delay_d  = delay_q;
      out_d    = out_q;
      valid_d  = valid_q;
      mem_we_c = 1'b0;

      if (run) begin
         delay_d = (delay > DELAY_W'(MAX_DELAY)) ? DELAY_W'(MAX_DELAY) : delay;
         wptr_d  = '0;
         cnt_d   = '0;
         valid_d = 1'b0;
         out_d   = '0;
      end else if (enable) begin
         mem_we_c = 1'b1;
         wptr_d   = (wptr_q == PTR_W'(MAX_DELAY - 1)) ? '0 : PTR_W'(wptr_q + 1'b1);

         // D=0 bypasses storage; otherwise the read sees the pre-write value,
         // so D=MAX_DELAY returns the entry about to be overwritten.
         if (delay_q == '0) begin
            out_d = in0;
         end else begin
`ifdef VDB_ZERO_FILL_EN
            if (cnt_q != delay_q) begin
               out_d = '0;
            end else begin
               out_d = mem_q[rptr_c];
            end
`else
            out_d = mem_q[rptr_c];
`endif
         end

         valid_d = (cnt_q == delay_q);
         if (cnt_q != delay_q) begin
            cnt_d = DELAY_W'(cnt_q + 1'b1);
         end
      end
   end

   // Control and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         cnt_q   <= '0;
         delay_q <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         cnt_q   <= cnt_d;
         delay_q <= delay_d;
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

   // Sample storage is intentionally left without reset.
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         mem_q[wptr_q] <= in0;
      end
   end

   assign out0      = out_q;
   assign out_valid = valid_q;
   assign delay_cur = delay_q;

endmodule
